// File: rtl/regfile_mp_if.sv
// Bus bundle for the multi-port register file. It carries the read, write-back, scoreboard
// and debug signals. The issuing side uses the master modport and the register file uses
// the slave modport.
interface regfile_mp_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned NUM_RD     = 2,
    parameter int unsigned NUM_WR     = 2
);
    logic                             ready;
    logic [NUM_RD*ADDR_WIDTH-1:0]     rd_addr;
    logic [NUM_RD*DATA_WIDTH-1:0]     rd_data;
    logic [NUM_RD-1:0]                rd_busy;
    logic [NUM_WR-1:0]                wr_en;
    logic [NUM_WR*ADDR_WIDTH-1:0]     wr_addr;
    logic [NUM_WR*DATA_WIDTH-1:0]     wr_data;
    logic                             sb_set;
    logic [ADDR_WIDTH-1:0]            sb_addr;
    logic                             dbg_we;
    logic [ADDR_WIDTH-1:0]            dbg_addr;
    logic [DATA_WIDTH-1:0]            dbg_wdata;
    logic [DATA_WIDTH-1:0]            dbg_rdata;
    logic                             dbg_ack;

    modport master (
        input  ready, rd_data, rd_busy, dbg_rdata, dbg_ack,
        output rd_addr, wr_en, wr_addr, wr_data, sb_set, sb_addr, dbg_we, dbg_addr, dbg_wdata
    );

    modport slave (
        output ready, rd_data, rd_busy, dbg_rdata, dbg_ack,
        input  rd_addr, wr_en, wr_addr, wr_data, sb_set, sb_addr, dbg_we, dbg_addr, dbg_wdata
    );
endinterface

// File: rtl/regfile_mp.sv
// Multi-port register file with these features:
// - prioritised write-back ports
// - write-through read bypass
// - per-register pending (busy) scoreboard
// - a zeroing sweep after reset
// - a debug access port
module regfile_mp #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned NUM_RD     = 2,
    parameter int unsigned NUM_WR     = 2,
    parameter bit          ZERO_REG   = 1'b1,
    parameter bit          BYPASS     = 1'b1
) (
    input  logic         i_clk,
    input  logic         i_rst,
    regfile_mp_if.slave  bus
);
    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

    typedef enum logic [0:0] {StInit, StRun} state_e;

    state_e                 r_state, w_state_next;
    logic [ADDR_WIDTH-1:0]  r_clr_cnt, w_clr_cnt_next;
    logic                   r_ready;
    logic                   r_dbg_ack;
    logic [DEPTH-1:0]       r_busy, w_busy_next;
    logic [DATA_WIDTH-1:0]  r_mem [DEPTH];
    logic [NUM_WR-1:0]      w_wq;
    logic                   w_run;
    logic                   w_dbg_acc;

    assign w_run = (r_state == StRun);

    // Sweep sequencing: INIT zeroes one entry per cycle and hands over to RUN after the last entry.
    always_comb begin
        w_state_next   = r_state;
        w_clr_cnt_next = r_clr_cnt;
        unique case (r_state)
            StInit: begin
                w_clr_cnt_next = r_clr_cnt + ADDR_WIDTH'(1);
                if (&r_clr_cnt) begin
                    w_state_next = StRun;
                end
            end
            StRun:   w_state_next = StRun;
            default: w_state_next = StInit;
        endcase
    end

    // Qualified core writes. Writes to entry 0 are discarded when it is hardwired to zero.
    always_comb begin
        w_wq = '0;
        for (int j = 0; j < NUM_WR; j++) begin
            w_wq[j] = w_run && bus.wr_en[j] &&
                      !(ZERO_REG && (bus.wr_addr[j*ADDR_WIDTH +: ADDR_WIDTH] == '0));
        end
    end

    // A debug write only gets through when no core write-back port is active this cycle.
    assign w_dbg_acc = w_run && bus.dbg_we && (bus.wr_en == '0) &&
                       !(ZERO_REG && (bus.dbg_addr == '0));

    // Scoreboard next state: write-back clears the busy bit, and issue sets it (set wins).
    always_comb begin
        w_busy_next = r_busy;
        for (int j = 0; j < NUM_WR; j++) begin
            if (w_wq[j]) begin
                w_busy_next[bus.wr_addr[j*ADDR_WIDTH +: ADDR_WIDTH]] = 1'b0;
            end
        end
        if (w_run && bus.sb_set && !(ZERO_REG && (bus.sb_addr == '0))) begin
            w_busy_next[bus.sb_addr] = 1'b1;
        end
    end

    // Control state with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= StInit;
            r_clr_cnt <= '0;
            r_ready   <= 1'b0;
            r_dbg_ack <= 1'b0;
            r_busy    <= '0;
        end else begin
            r_state   <= w_state_next;
            r_clr_cnt <= w_clr_cnt_next;
            r_ready   <= (w_state_next == StRun);
            r_dbg_ack <= w_dbg_acc;
            r_busy    <= w_busy_next;
        end
    end

    // Storage array. Only the sweep zeroes it, and a higher-index write port overrides lower ones.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            if (r_state == StInit) begin
                r_mem[r_clr_cnt] <= '0;
            end else begin
                if (w_dbg_acc) begin
                    r_mem[bus.dbg_addr] <= bus.dbg_wdata;
                end
                for (int j = 0; j < NUM_WR; j++) begin
                    if (w_wq[j]) begin
                        r_mem[bus.wr_addr[j*ADDR_WIDTH +: ADDR_WIDTH]] <=
                            bus.wr_data[j*DATA_WIDTH +: DATA_WIDTH];
                    end
                end
            end
        end
    end

    // Read ports. The data path forwards same-cycle core writes. Busy is taken from the registered bits only.
    always_comb begin
        bus.rd_data = '0;
        bus.rd_busy = '0;
        for (int i = 0; i < NUM_RD; i++) begin
            if (w_run && !(ZERO_REG && (bus.rd_addr[i*ADDR_WIDTH +: ADDR_WIDTH] == '0))) begin
                bus.rd_data[i*DATA_WIDTH +: DATA_WIDTH] =
                    r_mem[bus.rd_addr[i*ADDR_WIDTH +: ADDR_WIDTH]];
                bus.rd_busy[i] = r_busy[bus.rd_addr[i*ADDR_WIDTH +: ADDR_WIDTH]];
                if (BYPASS) begin
                    for (int j = 0; j < NUM_WR; j++) begin
                        if (w_wq[j] && (bus.wr_addr[j*ADDR_WIDTH +: ADDR_WIDTH] ==
                                        bus.rd_addr[i*ADDR_WIDTH +: ADDR_WIDTH])) begin
                            bus.rd_data[i*DATA_WIDTH +: DATA_WIDTH] =
                                bus.wr_data[j*DATA_WIDTH +: DATA_WIDTH];
                        end
                    end
                end
            end
        end
    end

    assign bus.dbg_rdata = w_run ? r_mem[bus.dbg_addr] : '0;
    assign bus.ready     = r_ready;
    assign bus.dbg_ack   = r_dbg_ack;
endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp with default parameters (32 x 32-bit, 2R/2W).
// Inputs change 1 ns after posedge, and outputs are sampled on negedge.
module tb_regfile_mp;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    regfile_mp_if bus ();

    regfile_mp dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  wr_en;
        logic [4:0]  wa0;
        logic [31:0] wd0;
        logic [4:0]  wa1;
        logic [31:0] wd1;
        logic [4:0]  ra0;
        logic [4:0]  ra1;
        logic        sb_set;
        logic [4:0]  sb_addr;
        logic        dbg_we;
        logic [4:0]  dbg_addr;
        logic [31:0] dbg_wdata;
        logic [31:0] exp_rd0;
        logic [31:0] exp_rd1;
        logic [1:0]  exp_busy;
        logic [31:0] exp_dbg_rdata;
        logic        exp_ack;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic idle();
        bus.wr_en     = '0;
        bus.wr_addr   = '0;
        bus.wr_data   = '0;
        bus.rd_addr   = '0;
        bus.sb_set    = 1'b0;
        bus.sb_addr   = '0;
        bus.dbg_we    = 1'b0;
        bus.dbg_addr  = '0;
        bus.dbg_wdata = '0;
    endtask

    // Counts negedges with ready low until ready rises. The count saturates at 200 if ready never rises.
    task automatic count_ready(output int n);
        n = 0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (bus.ready === 1'b1) break;
            n++;
        end
    endtask

    task automatic pulse_reset();
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        int n;
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        idle();

        // Fields: wr_en wa0 wd0 wa1 wd1 ra0 ra1 sb_set sb_addr dbg_we dbg_addr dbg_wdata |
        //         exp_rd0 exp_rd1 exp_busy exp_dbg_rdata exp_ack
        // Same-cycle dual write to x5: port 1 wins and is bypassed.
        vecs.push_back('{2'b11, 5'd5, 32'h11, 5'd5, 32'h22, 5'd5, 5'd5, 1'b0, 5'd0, 1'b0, 5'd0,
                         32'h0, 32'h22, 32'h22, 2'b00, 32'h0, 1'b0});
        vecs.push_back('{2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd5, 5'd6, 1'b0, 5'd0, 1'b0, 5'd0,
                         32'h0, 32'h22, 32'h0, 2'b00, 32'h0, 1'b0});
        // Debug write to x3 conflicts with a core write and is dropped.
        vecs.push_back('{2'b01, 5'd7, 32'h77, 5'd0, 32'h0, 5'd3, 5'd7, 1'b0, 5'd0, 1'b1, 5'd3,
                         32'h33, 32'h0, 32'h77, 2'b00, 32'h0, 1'b0});
        vecs.push_back('{2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd3, 5'd7, 1'b0, 5'd0, 1'b0, 5'd3,
                         32'h0, 32'h0, 32'h77, 2'b00, 32'h0, 1'b0});
        // Unopposed debug write: not bypassed, acked next cycle.
        vecs.push_back('{2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd3, 5'd0, 1'b0, 5'd0, 1'b1, 5'd3,
                         32'h33, 32'h0, 32'h0, 2'b00, 32'h0, 1'b0});
        vecs.push_back('{2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd3, 5'd0, 1'b0, 5'd0, 1'b0, 5'd3,
                         32'h0, 32'h33, 32'h0, 2'b00, 32'h33, 1'b1});
        vecs.push_back('{2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd3, 5'd0, 1'b0, 5'd0, 1'b0, 5'd3,
                         32'h0, 32'h33, 32'h0, 2'b00, 32'h33, 1'b0});
        // Scoreboard on x9: set, set+clear (set wins), then clear.
        vecs.push_back('{2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd9, 5'd0, 1'b1, 5'd9, 1'b0, 5'd0,
                         32'h0, 32'h0, 32'h0, 2'b00, 32'h0, 1'b0});
        vecs.push_back('{2'b01, 5'd9, 32'h99, 5'd0, 32'h0, 5'd9, 5'd0, 1'b1, 5'd9, 1'b0, 5'd0,
                         32'h0, 32'h99, 32'h0, 2'b01, 32'h0, 1'b0});
        vecs.push_back('{2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd9, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0,
                         32'h0, 32'h99, 32'h0, 2'b01, 32'h0, 1'b0});
        vecs.push_back('{2'b10, 5'd0, 32'h0, 5'd9, 32'h9A, 5'd9, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0,
                         32'h0, 32'h9A, 32'h0, 2'b01, 32'h0, 1'b0});
        vecs.push_back('{2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd9, 5'd0, 1'b0, 5'd0, 1'b0, 5'd9,
                         32'h0, 32'h9A, 32'h0, 2'b00, 32'h9A, 1'b0});
        // x0: core writes, sb_set and a debug write are all ignored.
        vecs.push_back('{2'b11, 5'd0, 32'hDEAD, 5'd0, 32'hDEAD, 5'd0, 5'd0, 1'b1, 5'd0, 1'b0, 5'd0,
                         32'h0, 32'h0, 32'h0, 2'b00, 32'h0, 1'b0});
        vecs.push_back('{2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd0,
                         32'hDEAD, 32'h0, 32'h0, 2'b00, 32'h0, 1'b0});
        vecs.push_back('{2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0,
                         32'h0, 32'h0, 32'h0, 2'b00, 32'h0, 1'b0});
        // Port 1 aimed at x0 must not suppress port 0 writing x4.
        vecs.push_back('{2'b11, 5'd4, 32'h44, 5'd0, 32'hDEAD, 5'd4, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0,
                         32'h0, 32'h44, 32'h0, 2'b00, 32'h0, 1'b0});
        vecs.push_back('{2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd4, 5'd5, 1'b0, 5'd0, 1'b0, 5'd4,
                         32'h0, 32'h44, 32'h22, 2'b00, 32'h44, 1'b0});

        // Reset held for two cycles. During reset ready stays low and the outputs are zero.
        @(posedge clk);
        @(negedge clk);
        chk("reset_ready", 32'(bus.ready), 32'h0);
        chk("reset_dbg_ack", 32'(bus.dbg_ack), 32'h0);
        @(posedge clk);
        #1 rst = 1'b0;
        count_ready(n);
        chk("reset_ready_latency", 32'(n), 32'd32);

        // Every readable entry is zero after the sweep.
        for (int a = 1; a < 32; a += 2) begin
            @(posedge clk);
            #1 bus.rd_addr = {5'(a + 1), 5'(a)};
            @(negedge clk);
            chk($sformatf("sweep_rd x%0d", a), bus.rd_data[31:0], 32'h0);
            if (a + 1 < 32) chk($sformatf("sweep_rd x%0d", a + 1), bus.rd_data[63:32], 32'h0);
        end

        for (int i = 0; i < vecs.size(); i++) begin
            @(posedge clk);
            #1;
            bus.wr_en     = vecs[i].wr_en;
            bus.wr_addr   = {vecs[i].wa1, vecs[i].wa0};
            bus.wr_data   = {vecs[i].wd1, vecs[i].wd0};
            bus.rd_addr   = {vecs[i].ra1, vecs[i].ra0};
            bus.sb_set    = vecs[i].sb_set;
            bus.sb_addr   = vecs[i].sb_addr;
            bus.dbg_we    = vecs[i].dbg_we;
            bus.dbg_addr  = vecs[i].dbg_addr;
            bus.dbg_wdata = vecs[i].dbg_wdata;
            @(negedge clk);
            chk($sformatf("v%0d rd0", i), bus.rd_data[31:0], vecs[i].exp_rd0);
            chk($sformatf("v%0d rd1", i), bus.rd_data[63:32], vecs[i].exp_rd1);
            chk($sformatf("v%0d busy", i), 32'(bus.rd_busy), 32'(vecs[i].exp_busy));
            chk($sformatf("v%0d dbg_rdata", i), bus.dbg_rdata, vecs[i].exp_dbg_rdata);
            chk($sformatf("v%0d dbg_ack", i), 32'(bus.dbg_ack), 32'(vecs[i].exp_ack));
        end

        // Mark x9 busy, then reset in the middle of the sweep. The sweep must restart and clear state.
        @(posedge clk);
        #1 idle();
        bus.sb_set  = 1'b1;
        bus.sb_addr = 5'd9;
        @(posedge clk);
        #1 idle();
        bus.rd_addr = {5'd5, 5'd9};
        @(negedge clk);
        chk("pre_reset_busy", 32'(bus.rd_busy), 32'h1);
        pulse_reset();
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk($sformatf("init_cycle%0d_ready", k), 32'(bus.ready), 32'h0);
            chk($sformatf("init_cycle%0d_rd", k), bus.rd_data[63:32], 32'h0);
        end
        pulse_reset();
        count_ready(n);
        chk("midsweep_ready_latency", 32'(n), 32'd32);
        @(negedge clk);
        chk("post_sweep_x9", bus.rd_data[31:0], 32'h0);
        chk("post_sweep_x5", bus.rd_data[63:32], 32'h0);
        chk("post_sweep_busy", 32'(bus.rd_busy), 32'h0);
        chk("post_sweep_ready", 32'(bus.ready), 32'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
